timekeeper: RTL and testbench

Seconds/minutes/hours time-of-day counter with a display-focus state machine. It sits directly upstream of the 3:1 display mux. Its `sec`, `min` and `hrs` outputs drive mux data inputs d0, d1 and d2, and its `sel` output drives the mux select `s`. The mux output is therefore always the field currently in focus. Button inputs let the user move focus and hand-set the focused field.

---
 rtl/timekeeper.sv | 114 +++++++++++
 tb/tb_timekeeper.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timekeeper.sv
// timekeeper: seconds/minutes/hours time-of-day counter with a display-focus
// state machine. sec/min/hrs feed the display mux data inputs, sel drives its
// select, so the mux always shows the field currently in focus. Mode moves
// focus, Inc hand-sets the focused field, Timer advances time unless Hold.
module timekeeper #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Timer,
    input  logic             Hold,
    input  logic             Mode,
    input  logic             Inc,
    output logic [WIDTH-1:0] sec,
    output logic [WIDTH-1:0] min,
    output logic [WIDTH-1:0] hrs,
    output logic [1:0]       sel,
    output logic             day_pulse
);

    typedef enum logic [1:0] {
        FOC_SEC = 2'b00,
        FOC_MIN = 2'b01,
        FOC_HRS = 2'b10
    } focus_t;

    localparam logic [WIDTH-1:0] SEC_LAST = WIDTH'(59);
    localparam logic [WIDTH-1:0] MIN_LAST = WIDTH'(59);
    localparam logic [WIDTH-1:0] HRS_LAST = WIDTH'(23);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    focus_t           focus;
    focus_t           focus_nxt;
    logic             mode_q;
    logic             inc_q;
    logic             mode_edge;
    logic             inc_edge;
    logic             tick;
    logic             sec_wrap;
    logic             min_wrap;
    logic             hrs_wrap;
    logic [WIDTH-1:0] sec_inc;
    logic [WIDTH-1:0] min_inc;
    logic [WIDTH-1:0] hrs_inc;

    // Button rising edges and the qualified time-advance tick (Inc wins over a tick)
    always_comb begin
        mode_edge = Mode & ~mode_q;
        inc_edge  = Inc & ~inc_q;
        tick      = Timer & ~Hold & ~inc_edge;
    end

    // Per-field modulo increments shared by tick counting and hand set
    always_comb begin
        sec_wrap = (sec == SEC_LAST);
        min_wrap = (min == MIN_LAST);
        hrs_wrap = (hrs == HRS_LAST);
        sec_inc  = sec_wrap ? '0 : sec + ONE;
        min_inc  = min_wrap ? '0 : min + ONE;
        hrs_inc  = hrs_wrap ? '0 : hrs + ONE;
    end

    // Focus next-state: Mode edge rotates SEC->MIN->HRS->SEC, illegal code recovers to SEC
    always_comb begin
        focus_nxt = FOC_SEC;
        case (focus)
            FOC_SEC: focus_nxt = mode_edge ? FOC_MIN : FOC_SEC;
            FOC_MIN: focus_nxt = mode_edge ? FOC_HRS : FOC_MIN;
            FOC_HRS: focus_nxt = mode_edge ? FOC_SEC : FOC_HRS;
            default: focus_nxt = FOC_SEC;
        endcase
    end

    // Registered state: button history, focus, time fields and day pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mode_q    <= 1'b1;
            inc_q     <= 1'b1;
            focus     <= FOC_SEC;
            sel       <= 2'b00;
            sec       <= '0;
            min       <= '0;
            hrs       <= '0;
            day_pulse <= 1'b0;
        end else begin
            mode_q    <= Mode;
            inc_q     <= Inc;
            focus     <= focus_nxt;
            sel       <= focus_nxt;
            day_pulse <= 1'b0;
            // Hand set acts on the focus held before any simultaneous Mode edge
            if (inc_edge) begin
                case (focus)
                    FOC_SEC: sec <= sec_inc;
                    FOC_MIN: min <= min_inc;
                    FOC_HRS: hrs <= hrs_inc;
                    default: ;
                endcase
            end else if (tick) begin
                sec <= sec_inc;
                if (sec_wrap) begin
                    min <= min_inc;
                    if (min_wrap) begin
                        hrs <= hrs_inc;
                        if (hrs_wrap) begin
                            day_pulse <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timekeeper.sv
// tb_timekeeper: directed stimulus with hand-computed expectations queued in a
// scoreboard; a negedge monitor pops entries due in the current cycle and
// compares them against the DUT outputs.
module tb_timekeeper;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Timer = 1'b0;
    logic       Hold = 1'b0;
    logic       Mode = 1'b1;
    logic       Inc = 1'b1;
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hrs;
    logic [1:0] sel;
    logic       day_pulse;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] m;
        logic [7:0] h;
        logic [1:0] sl;
        logic       dp;
    } snap_t;

    typedef struct {
        int unsigned at;
        snap_t       exp;
        string       name;
    } item_t;

    item_t       q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    timekeeper #(.WIDTH(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Timer     (Timer),
        .Hold      (Hold),
        .Mode      (Mode),
        .Inc       (Inc),
        .sec       (sec),
        .min       (min),
        .hrs       (hrs),
        .sel       (sel),
        .day_pulse (day_pulse)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: compare every scoreboard entry that falls due this cycle
    always @(negedge Clk) begin
        item_t it;
        snap_t act;
        while (q.size() > 0 && q[0].at <= cyc) begin
            it  = q.pop_front();
            act = {sec, min, hrs, sel, day_pulse};
            n_checks++;
            if (it.at != cyc) begin
                n_fail++;
                $display("FAIL %s: check due at cycle %0d missed (now %0d)", it.name, it.at, cyc);
            end else if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d:%0d:%0d sel=%b dp=%b, expected %0d:%0d:%0d sel=%b dp=%b",
                         it.name, act.h, act.m, act.s, act.sl, act.dp,
                         it.exp.h, it.exp.m, it.exp.s, it.exp.sl, it.exp.dp);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // off = 0: state visible now; off = 1: state after the next rising edge
    task automatic expect_at(input int unsigned off, input string n,
                             input int s, input int m, input int h,
                             input logic [1:0] sl, input logic dp);
        item_t it;
        it.at     = cyc + off;
        it.name   = n;
        it.exp.s  = 8'(s);
        it.exp.m  = 8'(m);
        it.exp.h  = 8'(h);
        it.exp.sl = sl;
        it.exp.dp = dp;
        q.push_back(it);
    endtask

    task automatic tap_inc(input int n);
        for (int i = 0; i < n; i++) begin
            Inc = 1'b1;
            step();
            Inc = 1'b0;
            step();
        end
    endtask

    task automatic tap_mode();
        Mode = 1'b1;
        step();
        Mode = 1'b0;
        step();
    endtask

    task automatic tap_mode_chk(input string n, input logic [1:0] sl);
        Mode = 1'b1;
        expect_at(1, n, 0, 0, 0, sl, 1'b0);
        step();
        Mode = 1'b0;
        step();
    endtask

    initial begin
        // Reset held two cycles with both buttons high
        step();
        step();
        expect_at(0, "reset", 0, 0, 0, 2'b00, 1'b0);
        Reset = 1'b0;
        expect_at(1, "rel_held1", 0, 0, 0, 2'b00, 1'b0);
        step();
        expect_at(1, "rel_held2", 0, 0, 0, 2'b00, 1'b0);
        step();
        Mode = 1'b0;
        Inc  = 1'b0;
        step();

        // Focus cycling
        tap_mode_chk("mode1", 2'b01);
        tap_mode_chk("mode2", 2'b10);
        tap_mode_chk("mode3", 2'b00);
        tap_mode_chk("mode4", 2'b01);

        // Minutes wrap by hand set, no carry into hours
        tap_inc(59);
        expect_at(0, "min59", 0, 59, 0, 2'b01, 1'b0);
        Inc = 1'b1;
        expect_at(1, "min_wrap", 0, 0, 0, 2'b01, 1'b0);
        step();
        Inc = 1'b0;
        step();

        // Hours wrap by hand set never raises day_pulse
        tap_mode();
        tap_inc(23);
        expect_at(0, "hrs23", 0, 0, 23, 2'b10, 1'b0);
        Inc = 1'b1;
        expect_at(1, "hrs_wrap", 0, 0, 0, 2'b10, 1'b0);
        step();
        Inc = 1'b0;
        expect_at(1, "hrs_wrap_dp", 0, 0, 0, 2'b10, 1'b0);
        step();

        // Build 23:59:59 and apply one tick
        tap_inc(23);
        tap_mode();
        tap_inc(59);
        tap_mode();
        tap_inc(59);
        expect_at(0, "t235959", 59, 59, 23, 2'b01, 1'b0);
        Timer = 1'b1;
        expect_at(1, "day_wrap", 0, 0, 0, 2'b01, 1'b1);
        step();
        Timer = 1'b0;
        expect_at(1, "day_pulse_end", 0, 0, 0, 2'b01, 1'b0);
        step();

        // 00:00:59 plus a tick
        tap_mode();
        tap_mode();
        tap_inc(59);
        Timer = 1'b1;
        expect_at(1, "sec_carry", 0, 1, 0, 2'b00, 1'b0);
        step();
        Timer = 1'b0;
        step();

        // Hold freezes ticks but not hand set
        Hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Timer = 1'b1;
            step();
            Timer = 1'b0;
            step();
        end
        expect_at(0, "hold_frozen", 0, 1, 0, 2'b00, 1'b0);
        Inc = 1'b1;
        expect_at(1, "hold_inc", 1, 1, 0, 2'b00, 1'b0);
        step();
        Inc  = 1'b0;
        step();
        Hold = 1'b0;

        // Inc collides with a tick: tick dropped
        tap_inc(4);
        expect_at(0, "pre_coll", 5, 1, 0, 2'b00, 1'b0);
        Timer = 1'b1;
        Inc   = 1'b1;
        expect_at(1, "collision", 6, 1, 0, 2'b00, 1'b0);
        step();
        Timer = 1'b0;
        Inc   = 1'b0;
        expect_at(1, "coll_after", 6, 1, 0, 2'b00, 1'b0);
        step();

        // Mode and Inc together: Inc uses old focus, focus advances
        Mode = 1'b1;
        Inc  = 1'b1;
        expect_at(1, "mode_inc", 7, 1, 0, 2'b01, 1'b0);
        step();
        Mode = 1'b0;
        Inc  = 1'b0;
        step();

        // Mode and tick together: both take effect
        Mode  = 1'b1;
        Timer = 1'b1;
        expect_at(1, "mode_tick", 8, 1, 0, 2'b10, 1'b0);
        step();
        Mode  = 1'b0;
        Timer = 1'b0;
        step();

        // 100 consecutive ticks, then reset coinciding with a tick
        Timer = 1'b1;
        repeat (100) step();
        expect_at(0, "run100", 48, 2, 0, 2'b10, 1'b0);
        Reset = 1'b1;
        expect_at(1, "reset_mid", 0, 0, 0, 2'b00, 1'b0);
        step();
        Reset = 1'b0;
        Timer = 1'b0;
        expect_at(1, "post_reset", 0, 0, 0, 2'b00, 1'b0);
        step();

        repeat (3) step();
        while (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never compared (due cycle %0d, now %0d)", it.name, it.at, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
